// File: rtl/spi_master_ctrl.sv
// Single-channel SPI master: one frame per valid/ready handshake, any CPOL/CPHA mode.
// Define SPI_MASTER_CTRL_BURST_EN to chain frames back-to-back without releasing ss_n.
module spi_master_ctrl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SS_SETUP = 2,
    parameter int unsigned SS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              ss_n
);
    localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
    localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

    state_e            state_q, state_d;
    logic              run_q;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ss_n_q, ss_n_d;

    logic stall;
    logic half_end;
    logic last_edge;
    logic burst_slot;
    logic accept;
    logic sample_edge;

    assign half_end  = (state_q == StXfer) && !stall && (div_q == DIV_W'(CLK_DIV - 1));
    assign last_edge = half_end && (edge_q == EDGE_W'(2 * DATA_W - 1));
    // edge_q counts edges already produced, so an even count means the next edge is leading.
    assign sample_edge = (edge_q[0] == cpha_q);

    assign tx_ready = run_q && ((state_q == StIdle) || burst_slot);
    assign accept   = tx_valid && tx_ready;

`ifdef SPI_MASTER_CTRL_BURST_EN
    logic restart_q, restart_d;

    // One idle divider cycle after a chained accept keeps frame spacing at 2*DATA_W*CLK_DIV+1.
    assign stall      = restart_q;
    assign burst_slot = last_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            restart_q <= 1'b0;
        end else begin
            restart_q <= restart_d;
        end
    end
`else
    assign stall      = 1'b0;
    assign burst_slot = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        edge_d     = edge_q;
        cnt_d      = cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
`ifdef SPI_MASTER_CTRL_BURST_EN
        restart_d  = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                sclk_d = cpol_q;
                if (accept) begin
                    cpol_d = cpol;
                    cpha_d = cpha;
                    sclk_d = cpol;
                    ss_n_d = 1'b0;
                    if (!cpha) begin
                        mosi_d  = tx_data[DATA_W-1];
                        tx_sh_d = tx_data << 1;
                    end else begin
                        tx_sh_d = tx_data;
                    end
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == CNT_W'(SS_SETUP - 1)) begin
                    div_d   = '0;
                    edge_d  = '0;
                    state_d = StXfer;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StXfer: begin
                if (half_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    if (sample_edge) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                    end else if (!last_edge) begin
                        mosi_d  = tx_sh_q[DATA_W-1];
                        tx_sh_d = tx_sh_q << 1;
                    end
                    if (last_edge) begin
`ifdef SPI_MASTER_CTRL_BURST_EN
                        if (accept) begin
                            edge_d     = '0;
                            restart_d  = 1'b1;
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_sh_d;
                            if (!cpha_q) begin
                                mosi_d  = tx_data[DATA_W-1];
                                tx_sh_d = tx_data << 1;
                            end else begin
                                tx_sh_d = tx_data;
                            end
                        end else begin
                            cnt_d   = '0;
                            state_d = StHold;
                        end
`else
                        cnt_d   = '0;
                        state_d = StHold;
`endif
                    end
                end else if (!stall) begin
                    div_d = div_q + 1'b1;
                end
            end

            StHold: begin
                if (cnt_q == CNT_W'(SS_HOLD - 1)) begin
                    ss_n_d     = 1'b1;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            run_q      <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            edge_q     <= '0;
            cnt_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            cnt_q      <= cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: directed mode frames, abort, back-to-back and random
// frames, checked against frame-level timing/data expectations and a bit-level SPI slave model.
module tb_spi_master_ctrl;
    localparam int unsigned DW  = 8;
    localparam int unsigned CD  = 4;
    localparam int unsigned SSU = 2;
    localparam int unsigned SSH = 2;
    localparam int unsigned XFER_CYC = 2 * DW * CD;
    localparam int unsigned LAT = SSU + XFER_CYC + SSH + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpol;
    logic          cpha;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          busy;
    logic          sclk;
    logic          mosi;
    logic          miso;
    logic          ss_n;

    int checks = 0;
    int errors = 0;

    // Slave model state
    logic          loopback;
    logic [DW-1:0] slave_word;
    logic          slave_cpha;
    logic          slave_miso;
    logic          prev_ss = 1'b1;
    logic          prev_sclk = 1'b0;
    int            s_edges = 0;
    int            s_bits = 0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slave_miso;

    spi_master_ctrl #(
        .DATA_W  (DW),
        .CLK_DIV (CD),
        .SS_SETUP(SSU),
        .SS_HOLD (SSH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cpol    (cpol),
        .cpha    (cpha),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .ss_n    (ss_n)
    );

    // Slave presents bit k of its word until the master's k-th sampling edge has passed.
    always @(negedge clk) begin
        if (!ss_n && prev_ss) begin
            s_edges    = 0;
            s_bits     = 0;
            slave_miso = slave_word[DW-1];
        end else if (!ss_n && (sclk !== prev_sclk)) begin
            s_edges = s_edges + 1;
            if (((s_edges % 2) == 1) == !slave_cpha) begin
                s_bits = s_bits + 1;
                if (s_bits < DW) slave_miso = slave_word[DW-1-s_bits];
            end
        end
        prev_ss   = ss_n;
        prev_sclk = sclk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_ready(input string name);
        int waited = 0;
        @(negedge clk);
        while (tx_ready !== 1'b1 && waited < 4 * LAT) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: tx_ready=%b, required 1", name, tx_ready);
        end
    endtask

    // One frame: accept at cycle 0, then observe cycles 1..LAT+1 and compare with the rules.
    task automatic run_frame(input logic [DW-1:0] data, input logic pol, input logic pha,
                             input logic [DW-1:0] sword, input logic loop, input string name);
        int            edge_cyc[$];
        logic [DW-1:0] mosi_word = '0;
        logic [DW-1:0] exp_rx;
        logic [DW-1:0] rxd_at = '0;
        int            rxv_cnt = 0;
        int            rxv_first = -1;
        int            ss_bad = 0;
        int            time_bad = 0;
        logic          ps = 1'b0;
        logic          sclk_first = 1'b0;
        logic          sclk_end = 1'b0;
        logic          ready_end = 1'b0;
        logic          busy_end = 1'b1;
        logic          busy_first = 1'b0;

        loopback   = loop;
        slave_word = sword;
        slave_cpha = pha;
        exp_rx     = loop ? data : sword;
        wait_ready(name);
        tx_data  = data;
        cpol     = pol;
        cpha     = pha;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = DW'($urandom);
        cpol     = 1'($urandom);
        cpha     = 1'($urandom);
        for (int c = 1; c <= int'(LAT) + 1; c++) begin
            @(negedge clk);
            if (ss_n !== ((c < int'(LAT)) ? 1'b0 : 1'b1)) ss_bad++;
            if (c == 1) begin
                sclk_first = sclk;
                busy_first = busy;
            end else if (sclk !== ps) begin
                edge_cyc.push_back(c);
                if (((edge_cyc.size() % 2) == 1) == !pha) mosi_word = {mosi_word[DW-2:0], mosi};
            end
            ps = sclk;
            if (rx_valid === 1'b1) begin
                rxv_cnt++;
                if (rxv_first < 0) begin
                    rxv_first = c;
                    rxd_at    = rx_data;
                end
            end
            if (c == int'(LAT)) begin
                sclk_end  = sclk;
                ready_end = tx_ready;
                busy_end  = busy;
            end
        end
        foreach (edge_cyc[j]) if (edge_cyc[j] != int'(SSU + (j + 1) * CD + 1)) time_bad++;

        checks++;
        if (ss_bad !== 0) begin
            errors++;
            $display("FAIL %s ss_window: %0d cycles wrong, required 0", name, ss_bad);
        end
        checks++;
        if (sclk_first !== pol || sclk_end !== pol) begin
            errors++;
            $display("FAIL %s sclk_idle: start=%b end=%b, required %b", name, sclk_first,
                     sclk_end, pol);
        end
        checks++;
        if (edge_cyc.size() != 2 * DW || time_bad != 0) begin
            errors++;
            $display("FAIL %s sclk_edges: count=%0d mistimed=%0d, required %0d and 0", name,
                     edge_cyc.size(), time_bad, 2 * DW);
        end
        checks++;
        if (mosi_word !== data) begin
            errors++;
            $display("FAIL %s mosi_bits: got %h, required %h", name, mosi_word, data);
        end
        checks++;
        if (rxv_cnt != 1 || rxv_first != int'(LAT)) begin
            errors++;
            $display("FAIL %s rx_valid: pulses=%0d first=%0d, required 1 at %0d", name, rxv_cnt,
                     rxv_first, LAT);
        end
        checks++;
        if (rxd_at !== exp_rx) begin
            errors++;
            $display("FAIL %s rx_data: got %h, required %h", name, rxd_at, exp_rx);
        end
        checks++;
        if (ready_end !== 1'b1 || busy_end !== 1'b0 || busy_first !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: ready_end=%b busy_end=%b busy_first=%b, required 1 0 1",
                     name, ready_end, busy_end, busy_first);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx_ready, rx_valid, busy, sclk, mosi, ss_n} !== 6'b000001 || rx_data !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy/rxv/busy/sclk/mosi/ss_n=%b rx_data=%h, required 000001 00",
                     {tx_ready, rx_valid, busy, sclk, mosi, ss_n}, rx_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: tx_ready=%b busy=%b, required 1 0", tx_ready, busy);
        end
    endtask

    task automatic test_mode0();
        run_frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, "mode0_loop");
    endtask

    task automatic test_mode3();
        run_frame(8'h3C, 1'b1, 1'b1, 8'hC3, 1'b0, "mode3_slave");
    endtask

    task automatic test_mode1_mode2();
        run_frame(8'h81, 1'b0, 1'b1, 8'h4E, 1'b0, "mode1");
        run_frame(8'h81, 1'b1, 1'b0, 8'hB2, 1'b0, "mode2");
    endtask

    task automatic test_abort();
        int   edges = 0;
        int   n = 0;
        int   rxv = 0;
        int   ss_bad = 0;
        logic ps;
        loopback = 1'b1;
        wait_ready("abort");
        tx_data  = 8'h96;
        cpol     = 1'b0;
        cpha     = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        @(negedge clk);
        ps = sclk;
        while (edges < 5 && n < int'(LAT)) begin
            @(negedge clk);
            n++;
            if (sclk !== ps) edges++;
            ps = sclk;
        end
        checks++;
        if (edges != 5) begin
            errors++;
            $display("FAIL abort_edge_wait: saw %0d edges, required 5", edges);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ss_n, sclk, tx_ready, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_async: ss_n/sclk/ready/busy=%b, required 1000",
                     {ss_n, sclk, tx_ready, busy});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) rxv++;
        end
        rst = 1'b0;
        for (int i = 0; i < int'(LAT); i++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) rxv++;
            if (ss_n !== 1'b1) ss_bad++;
        end
        checks++;
        if (rxv != 0 || ss_bad != 0) begin
            errors++;
            $display("FAIL abort_quiet: rx_valid pulses=%0d ss_n low cycles=%0d, required 0 0",
                     rxv, ss_bad);
        end
        run_frame(8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, "abort_next");
    endtask

`ifndef SPI_MASTER_CTRL_BURST_EN
    // tx_valid held high: each frame gets its own ss_n window with one idle cycle between.
    task automatic test_back_to_back();
        int            rxv_cyc[$];
        logic [DW-1:0] rxv_dat[$];
        int            ss_bad = 0;
        logic          exp_ss;
        loopback = 1'b1;
        wait_ready("b2b");
        tx_data  = 8'h11;
        cpol     = 1'b0;
        cpha     = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'h22;
        for (int c = 1; c <= 2 * int'(LAT) + 1; c++) begin
            @(negedge clk);
            if (c == int'(LAT) + 1) begin
                tx_valid = 1'b0;
                tx_data  = DW'($urandom);
                cpol     = 1'($urandom);
            end
            exp_ss = !((c >= 1 && c < int'(LAT)) || (c > int'(LAT) && c < 2 * int'(LAT)));
            if (ss_n !== exp_ss) ss_bad++;
            if (rx_valid === 1'b1) begin
                rxv_cyc.push_back(c);
                rxv_dat.push_back(rx_data);
            end
        end
        checks++;
        if (ss_bad != 0) begin
            errors++;
            $display("FAIL b2b_ss_windows: %0d cycles wrong, required 0", ss_bad);
        end
        checks++;
        if (rxv_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_rx_count: got %0d pulses, required 2", rxv_cyc.size());
        end else begin
            checks++;
            if (rxv_cyc[0] != int'(LAT) || rxv_cyc[1] != 2 * int'(LAT)) begin
                errors++;
                $display("FAIL b2b_rx_timing: got %0d,%0d required %0d,%0d", rxv_cyc[0],
                         rxv_cyc[1], LAT, 2 * LAT);
            end
            checks++;
            if (rxv_dat[0] !== 8'h11 || rxv_dat[1] !== 8'h22) begin
                errors++;
                $display("FAIL b2b_rx_data: got %h,%h required 11,22", rxv_dat[0], rxv_dat[1]);
            end
        end
    endtask
`else
    // Three chained frames: ss_n stays low, one HOLD at the very end.
    task automatic test_burst();
        logic [DW-1:0] words[3];
        int            rxv_cyc[$];
        logic [DW-1:0] rxv_dat[$];
        int            r1, r2, r3;
        int            idx = 1;
        int            accepts = 1;
        int            edges = 0;
        int            ss_bad = 0;
        logic          acc_pending = 1'b0;
        logic          ps;
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        r1 = int'(SSU + XFER_CYC + 1);
        r2 = r1 + int'(XFER_CYC) + 1;
        r3 = r2 + int'(XFER_CYC) + 1 + int'(SSH);
        loopback = 1'b1;
        wait_ready("burst");
        tx_data  = words[0];
        cpol     = 1'b0;
        cpha     = 1'b0;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = words[1];
        ps = sclk;
        for (int c = 1; c <= r3 + 1; c++) begin
            @(negedge clk);
            if (acc_pending) begin
                acc_pending = 1'b0;
                accepts++;
                idx++;
                if (idx < 3) tx_data = words[idx];
                else tx_valid = 1'b0;
            end
            if (c > 1 && sclk !== ps) edges++;
            ps = sclk;
            if (ss_n !== ((c < r3) ? 1'b0 : 1'b1)) ss_bad++;
            if (rx_valid === 1'b1) begin
                rxv_cyc.push_back(c);
                rxv_dat.push_back(rx_data);
            end
            if (tx_valid && tx_ready) acc_pending = 1'b1;
        end
        checks++;
        if (ss_bad != 0 || accepts != 3) begin
            errors++;
            $display("FAIL burst_ss: bad cycles=%0d accepts=%0d, required 0 and 3", ss_bad, accepts);
        end
        checks++;
        if (edges != 6 * int'(DW)) begin
            errors++;
            $display("FAIL burst_edges: got %0d, required %0d", edges, 6 * DW);
        end
        checks++;
        if (rxv_cyc.size() != 3) begin
            errors++;
            $display("FAIL burst_rx_count: got %0d, required 3", rxv_cyc.size());
        end else begin
            checks++;
            if (rxv_cyc[0] != r1 || rxv_cyc[1] != r2 || rxv_cyc[2] != r3) begin
                errors++;
                $display("FAIL burst_rx_timing: got %0d,%0d,%0d required %0d,%0d,%0d",
                         rxv_cyc[0], rxv_cyc[1], rxv_cyc[2], r1, r2, r3);
            end
            checks++;
            if (rxv_dat[0] !== words[0] || rxv_dat[1] !== words[1] || rxv_dat[2] !== words[2]) begin
                errors++;
                $display("FAIL burst_rx_data: got %h,%h,%h required 11,22,33", rxv_dat[0],
                         rxv_dat[1], rxv_dat[2]);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_frame(DW'($urandom), 1'($urandom), 1'($urandom), DW'($urandom), 1'b0, "random");
        end
    endtask

    initial begin
        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = '0;
        cpol       = 1'b0;
        cpha       = 1'b0;
        loopback   = 1'b1;
        slave_word = '0;
        slave_cpha = 1'b0;
        slave_miso = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_mode1_mode2();
        test_abort();
`ifndef SPI_MASTER_CTRL_BURST_EN
        test_back_to_back();
`else
        test_burst();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
Single-channel SPI master controller that sequences one frame at a time onto the SPI bus signals sclk, mosi, miso and ss_n. It accepts a parallel TX word through a valid/ready handshake, asserts slave select with programmable setup and hold, and generates SCLK in any of the four CPOL/CPHA modes. It returns the captured MISO word with a one-cycle strobe. It sits between a register/sequence layer and the physical SPI bus, and is the design-side counterpart that the SPI VIP agent exercises.

Parameters:
DATA_W, 8, bits per frame; range 2..32.
CLK_DIV, 4, clk cycles per SCLK half-period; range 1..255.
SS_SETUP, 2, clk cycles with ss_n low before the first SCLK edge; range 1..15.
SS_HOLD, 2, clk cycles with ss_n low after the last SCLK edge; range 1..15.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  asynchronous reset, active-high.
cpol  in  1  SCLK idle level; sampled on accept.
cpha  in  1  0 = sample on the leading edge, 1 = sample on the trailing edge; sampled on accept.
tx_data  in  DATA_W  frame to send, MSB first.
tx_valid  in  1  request for a frame.
tx_ready  out  1  controller can accept a frame.
rx_data  out  DATA_W  captured MISO word; valid while rx_valid is high, held afterwards.
rx_valid  out  1  one-cycle completion strobe.
busy  out  1  high in any state other than IDLE.
sclk  out  1  SPI clock, registered.
mosi  out  1  SPI data out, registered.
miso  in  1  SPI data in; synchronous to SCLK and sampled directly.
ss_n  out  1  active-low slave select, registered.

Behaviour:
- Reset values:
  - Outputs: tx_ready=0, rx_valid=0, busy=0, rx_data=0, sclk=0, mosi=0, ss_n=1.
  - Internal: latched cpol=0, state=IDLE.
  - First cycle after reset release: tx_ready=1.
- A reset asserted mid-frame aborts the frame immediately: ss_n=1 asynchronously and no rx_valid is produced.
- States are IDLE, SETUP, XFER and HOLD.
- IDLE:
  - tx_ready=1, ss_n=1, sclk=latched cpol.
  - Accept occurs on a cycle with tx_valid & tx_ready.
  - On accept, latch tx_data, cpol and cpha; set sclk to the new cpol and ss_n=0; go to SETUP.
  - mosi is set to tx_data[MSB] when cpha=0 and held at its previous value when cpha=1.
- SETUP: lasts SS_SETUP cycles, then go to XFER.
- XFER:
  - A divider counts CLK_DIV cycles per half-period. sclk toggles at the end of each half-period, giving exactly 2*DATA_W edges.
  - The leading edge is the odd-numbered edge.
  - cpha=0: sample miso on leading edges; shift the next bit out on trailing edges, except after the final edge.
  - cpha=1: drive the next bit on leading edges (MSB on the first); sample on trailing edges.
  - After edge 2*DATA_W, sclk equals cpol. Go to HOLD.
- HOLD: ss_n stays 0 for SS_HOLD cycles. Then ss_n=1, state=IDLE, rx_valid=1 for one cycle, and rx_data is updated in that same cycle.
- Latency: accept at cycle 0 gives rx_valid at cycle SS_SETUP + 2*DATA_W*CLK_DIV + SS_HOLD + 1.
  - tx_ready is high in the rx_valid cycle.
  - ss_n is high for at least one cycle between frames.
- tx_data, cpol and cpha changes while busy are ignored.
- tx_valid may drop without acceptance; nothing happens.
- mosi holds its last bit in HOLD and IDLE.

Optional Feature:
SPI_MASTER_CTRL_BURST_EN.
- With the macro defined:
  - tx_ready is also high in the last XFER cycle, the one that produces edge 2*DATA_W.
  - If a frame is accepted there, ss_n stays 0, SETUP and HOLD are skipped, and XFER restarts next cycle with the new data.
  - cpol and cpha are not re-sampled.
  - rx_valid for the completed frame pulses in the cycle after acceptance.
  - Consecutive frames are therefore spaced 2*DATA_W*CLK_DIV + 1 cycles apart, with no ss_n deassertion.
  - No accept in that cycle gives normal HOLD behaviour.
- Without the macro: tx_ready is high only in IDLE, and every frame has its own SETUP/HOLD and ss_n pulse.

Test Plan:
1. Reset then mode 0 (cpol=0, cpha=0), tx_data=0xA5, miso looped to mosi, defaults -> ss_n low at cycle 1, 16 sclk edges each 4 clks, rx_valid at cycle 69, rx_data=0xA5.
2. Mode 3 (cpol=1, cpha=1), tx_data=0x3C, slave model returns 0xC3 -> sclk idles high before and after, mosi changes on falling edges, rx_data=0xC3.
3. Mode 1 and mode 2 with tx_data=0x81, CLK_DIV=1 -> sclk period of 2 clks, 16 edges, rx_valid at cycle 21 with SS_SETUP=SS_HOLD=2, correct capture edge per mode.
4. rst asserted on the 5th sclk edge of a frame -> ss_n=1, sclk=0 and tx_ready=0 in the same cycle. No rx_valid. The next frame 0x5A completes normally.
5. tx_valid held high with 0x11 then 0x22, no burst -> two ss_n low windows separated by at least 1 high cycle, two rx_valid pulses, data changes while busy ignored.
6. BURST_EN defined, 0x11, 0x22, 0x33 back-to-back -> ss_n low continuously for 48 edges, rx_valid pulses 65 cycles apart, single HOLD at the end.
